// File: rtl/spi_flash_master.sv
// SPI mode-0 byte-exchange master for serial flash: one enable-framed transaction,
// further bytes on continue pulses, one-deep pending request, enforced CS recovery gap.
module spi_flash_master #(
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       FLASH_enable,
    input  logic       FLASH_continue_read,
    input  logic [7:0] FLASH_data_out,
    output logic [7:0] FLASH_data_in,
    output logic       FLASH_busy,
    output logic       FLASH_CS_n,
    output logic       FLASH_SCK,
    output logic       FLASH_MOSI,
    input  logic       FLASH_MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

    localparam logic [15:0] HALF_LAST = 16'(SCK_HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [6:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_en_q;
    logic        r_armed;
    logic        r_rise_held;
    logic        r_pending;

    logic        w_rise;
    logic        w_in_byte;
    logic        w_cnt_last;
    logic        w_start;

    // r_armed blocks an enable that was already high across reset from looking like a new edge
    assign w_rise     = FLASH_enable & ~r_en_q & r_armed;
    assign w_in_byte  = (r_state == SETUP) || (r_state == SCK_HI) || (r_state == SCK_LO);
    assign w_cnt_last = (r_cnt == HALF_LAST);
    assign w_start    = ((r_state == IDLE) && (w_rise || r_rise_held)) ||
                        ((r_state == HOLD) && FLASH_enable && (FLASH_continue_read || r_pending));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_en_q        <= 1'b0;
            r_armed       <= 1'b0;
            r_rise_held   <= 1'b0;
            r_pending     <= 1'b0;
            FLASH_data_in <= '0;
            FLASH_busy    <= 1'b0;
            FLASH_CS_n    <= 1'b1;
            FLASH_SCK     <= 1'b0;
            FLASH_MOSI    <= 1'b0;
        end else begin
            r_en_q <= FLASH_enable;
            if (!FLASH_enable) r_armed <= 1'b1;
            if (w_in_byte && FLASH_continue_read) r_pending <= 1'b1;

            case (r_state)
                IDLE: r_rise_held <= 1'b0;
                SETUP: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        FLASH_SCK <= 1'b1;
                        r_state   <= SCK_HI;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                SCK_HI: begin
                    if (w_cnt_last) begin
                        r_cnt      <= '0;
                        r_rx       <= {r_rx[6:0], FLASH_MISO};
                        FLASH_MOSI <= r_tx[6];
                        r_tx       <= {r_tx[5:0], 1'b0};
                        FLASH_SCK  <= 1'b0;
                        r_state    <= SCK_LO;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                SCK_LO: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            FLASH_data_in <= r_rx;
                            // an enable that dropped mid-byte skips HOLD and discards any pending request
                            if (FLASH_enable) begin
                                FLASH_busy <= 1'b0;
                                r_state    <= HOLD;
                            end else begin
                                FLASH_CS_n <= 1'b1;
                                r_pending  <= 1'b0;
                                r_state    <= GAP;
                            end
                        end else begin
                            FLASH_SCK <= 1'b1;
                            r_state   <= SCK_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (!FLASH_enable) begin
                        FLASH_CS_n <= 1'b1;
                        FLASH_busy <= 1'b1;
                        r_pending  <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= GAP;
                    end
                end
                GAP: begin
                    if (w_rise) r_rise_held <= 1'b1;
                    if (r_cnt == GAP_LAST) begin
                        r_cnt      <= '0;
                        FLASH_busy <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_start) begin
                r_state     <= SETUP;
                r_cnt       <= '0;
                r_bit       <= '0;
                r_tx        <= FLASH_data_out[6:0];
                FLASH_MOSI  <= FLASH_data_out[7];
                FLASH_CS_n  <= 1'b0;
                FLASH_SCK   <= 1'b0;
                FLASH_busy  <= 1'b1;
                r_pending   <= 1'b0;
                r_rise_held <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_master.sv
// Scoreboard bench for spi_flash_master: a flash-slave monitor replays queued MISO bytes
// and checks MOSI, received byte, SCK period, busy length and CS gap for each exchange.
module tb_spi_flash_master;
    localparam int CS_GAP = 4;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cont;
    logic [7:0] dout;
    logic       miso;
    logic       sel;
    int         h_cur;

    logic [7:0] din_a, din_b;
    logic       busy_a, busy_b, cs_a, cs_b, sck_a, sck_b, mosi_a, mosi_b;
    logic [7:0] m_din;
    logic       m_busy, m_cs, m_sck, m_mosi;

    exp_t       sb[$];
    exp_t       cur;
    logic       have_cur;
    logic [7:0] mosi_sh;
    logic       period_ok;
    logic       prev_sck, prev_busy, prev_cs;
    int         bitcnt, fallcnt, countdown, since_rise;
    int         busy_cnt, gap_cnt, cs_hi_cnt, cs_rises, rises_total, bytes_done;
    int         checks = 0;
    int         fails = 0;
    int         r0;

    spi_flash_master #(.SCK_HALF(2), .CS_GAP(CS_GAP)) dut_a (
        .clk_in(clk), .reset(reset), .FLASH_enable(en), .FLASH_continue_read(cont),
        .FLASH_data_out(dout), .FLASH_data_in(din_a), .FLASH_busy(busy_a),
        .FLASH_CS_n(cs_a), .FLASH_SCK(sck_a), .FLASH_MOSI(mosi_a), .FLASH_MISO(miso)
    );

    spi_flash_master #(.SCK_HALF(1), .CS_GAP(CS_GAP)) dut_b (
        .clk_in(clk), .reset(reset), .FLASH_enable(en), .FLASH_continue_read(cont),
        .FLASH_data_out(dout), .FLASH_data_in(din_b), .FLASH_busy(busy_b),
        .FLASH_CS_n(cs_b), .FLASH_SCK(sck_b), .FLASH_MOSI(mosi_b), .FLASH_MISO(miso)
    );

    assign m_din  = sel ? din_b  : din_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_cs   = sel ? cs_b   : cs_a;
    assign m_sck  = sel ? sck_b  : sck_a;
    assign m_mosi = sel ? mosi_b : mosi_a;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] tx, input logic [7:0] rx);
        exp_t e;
        e.tx = tx;
        e.rx = rx;
        sb.push_back(e);
    endtask

    task automatic pulse();
        cont = 1'b1;
        tick(1);
        cont = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        tick(1);
        while (!(sb.size() == 0 && !have_cur && !m_busy) && n < maxc) begin
            tick(1);
            n++;
        end
        if (n >= maxc) check("drain_timeout", 32'(n), 32'(maxc - 1));
    endtask

    task automatic wait_level(input string name, input int which, input logic lvl, input int maxc);
        int n;
        logic v;
        n = 0;
        v = (which == 0) ? m_busy : m_cs;
        while (v !== lvl && n < maxc) begin
            tick(1);
            n++;
            v = (which == 0) ? m_busy : m_cs;
        end
        if (n >= maxc) check(name, 32'(v), 32'(lvl));
    endtask

    // Flash slave model and scoreboard monitor, sampled on the falling clock edge.
    initial begin
        miso = 1'b0; have_cur = 1'b0; cur = '0; mosi_sh = '0; period_ok = 1'b1;
        prev_sck = 1'b0; prev_busy = 1'b0; prev_cs = 1'b1;
        bitcnt = 0; fallcnt = 0; countdown = 0; since_rise = 0;
        busy_cnt = 0; gap_cnt = 0; cs_hi_cnt = 0; cs_rises = 0; rises_total = 0; bytes_done = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bitcnt = 0; fallcnt = 0; countdown = 0; have_cur = 1'b0;
                busy_cnt = 0; gap_cnt = 0; cs_hi_cnt = 0;
                prev_sck = 1'b0; prev_busy = 1'b0; prev_cs = 1'b1; miso = 1'b0;
            end else begin
                since_rise++;
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        check("rx_byte", 32'(m_din), 32'(cur.rx));
                        check("tx_byte", 32'(mosi_sh), 32'(cur.tx));
                        check("sck_period", 32'(period_ok), 32'd1);
                        have_cur = 1'b0; bitcnt = 0; fallcnt = 0; bytes_done++;
                    end
                end
                if (m_sck && !prev_sck) begin
                    rises_total++;
                    if (bitcnt == 0) begin
                        period_ok = 1'b1;
                        if (!have_cur) check("unexpected_byte", 32'(have_cur), 32'd1);
                    end else if (since_rise != 2 * h_cur) begin
                        period_ok = 1'b0;
                    end
                    since_rise = 0;
                    mosi_sh = {mosi_sh[6:0], m_mosi};
                    bitcnt++;
                    if (bitcnt == 8) countdown = 2 * h_cur;
                end
                if (prev_sck && !m_sck) fallcnt++;
                if (m_busy) begin
                    busy_cnt++;
                    if (m_cs) gap_cnt++;
                end else begin
                    if (prev_busy && !m_cs) check("busy_len", 32'(busy_cnt), 32'(17 * h_cur));
                    if (prev_busy && m_cs) check("gap_len", 32'(gap_cnt), 32'(CS_GAP));
                    busy_cnt = 0;
                    gap_cnt = 0;
                end
                if (m_cs) begin
                    cs_hi_cnt++;
                    if (!prev_cs) cs_rises++;
                end else begin
                    if (prev_cs) check("cs_gap_min", 32'(cs_hi_cnt >= CS_GAP), 32'd1);
                    cs_hi_cnt = 0;
                end
                if (!have_cur && bitcnt == 0 && sb.size() > 0) begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                end
                prev_sck = m_sck; prev_busy = m_busy; prev_cs = m_cs;
                miso = (have_cur && fallcnt < 8) ? cur.rx[7 - fallcnt] : 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; cont = 1'b0; dout = '0; sel = 1'b0; h_cur = 2;
        tick(3);
        check("rst_cs_n", 32'(m_cs), 32'd1);
        check("rst_sck", 32'(m_sck), 32'd0);
        check("rst_mosi", 32'(m_mosi), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_din", 32'(m_din), 32'd0);
        reset = 1'b0;
        tick(6);

        // Single byte: 0x9F out, 0xA5 back
        push(8'h9F, 8'hA5); dout = 8'h9F; en = 1'b1;
        tick(1);
        check("start_cs_n", 32'(m_cs), 32'd0);
        check("start_busy", 32'(m_busy), 32'd1);
        check("start_mosi", 32'(m_mosi), 32'd1);
        drain(300);
        check("hold_cs_n", 32'(m_cs), 32'd0);
        r0 = cs_rises;

        // Three continue reads
        push(8'h00, 8'hEF); dout = 8'h00; pulse(); drain(300);
        push(8'h00, 8'h40); pulse(); drain(300);
        push(8'h00, 8'h18); pulse(); drain(300);
        check("din_last", 32'(m_din), 32'h18);

        // Pending continue, second pulse in the same byte dropped
        push(8'h3C, 8'h5A); dout = 8'h3C; pulse();
        tick(10);
        push(8'hC3, 8'h96); dout = 8'hC3; pulse();
        tick(5);
        pulse();
        wait_level("busy_fall_timeout", 0, 1'b0, 100);
        tick(1);
        check("pending_served", 32'(m_busy), 32'd1);
        drain(300);
        tick(40);
        check("cs_stayed_low", 32'(cs_rises - r0), 32'd0);
        check("bytes_after_pending", 32'(bytes_done), 32'd6);

        // Enable falls mid-byte, re-rises during the gap
        push(8'h05, 8'h81); dout = 8'h05; pulse();
        tick(14);
        en = 1'b0;
        wait_level("cs_rise_timeout", 1, 1'b1, 100);
        tick(2);
        push(8'h9F, 8'hC2); dout = 8'h9F; en = 1'b1;
        drain(300);
        check("gap_restart_cs_n", 32'(m_cs), 32'd0);

        // Reset during bit 5
        push(8'hAA, 8'h33); dout = 8'hAA; pulse();
        tick(21);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_cs_n", 32'(m_cs), 32'd1);
        check("arst_sck", 32'(m_sck), 32'd0);
        check("arst_busy", 32'(m_busy), 32'd0);
        check("arst_din", 32'(m_din), 32'd0);
        tick(2);
        reset = 1'b0;
        r0 = rises_total;
        tick(60);
        check("no_sck_after_reset", 32'(rises_total - r0), 32'd0);
        check("idle_cs_after_reset", 32'(m_cs), 32'd1);
        en = 1'b0;
        tick(3);
        push(8'h9F, 8'h7E); dout = 8'h9F; en = 1'b1;
        drain(300);
        en = 1'b0;
        tick(12);

        // Fastest SCK
        reset = 1'b1; sel = 1'b1; h_cur = 1;
        tick(2);
        reset = 1'b0;
        tick(6);
        push(8'h9F, 8'h5C); dout = 8'h9F; en = 1'b1;
        drain(200);
        push(8'h12, 8'hE7); dout = 8'h12; pulse();
        drain(200);
        en = 1'b0;
        tick(12);

        check("byte_count", 32'(bytes_done), 32'd11);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/spi_flash_master.md
SPI_FLASH_MASTER -- requirements
Module: spi_flash_master

Interface
REQ-001 Parameter: SCK_HALF, default 2, clk_in cycles per SCK half-period (legal range 1..255).
REQ-002 Parameter: CS_GAP, default 4, minimum clk_in cycles FLASH_CS_n stays high between transactions.
REQ-003 clk_in  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 FLASH_enable  input  1  level; 0->1 opens a transaction and sends the first byte, 1->0 closes it.
REQ-006 FLASH_continue_read  input  1  one-cycle pulse; exchanges the next byte within the open transaction.
REQ-007 FLASH_data_out  input  8  byte to transmit; sampled when a byte exchange starts.
REQ-008 FLASH_data_in  output  8  last byte received from MISO.
REQ-009 FLASH_busy  output  1  high while a byte exchange or the CS gap is in progress.
REQ-010 FLASH_CS_n  output  1  flash chip select, active low.
REQ-011 FLASH_SCK  output  1  SPI clock, mode 0 (idle low).
REQ-012 FLASH_MOSI  output  1  serial data to flash, MSB first.
REQ-013 FLASH_MISO  input  1  serial data from flash, MSB first.

Function
REQ-014 States SHALL be: IDLE, SETUP, SCK_HI, SCK_LO, HOLD (CS low, waiting), GAP (CS high, recovering).
REQ-015 The block SHALL detect FLASH_enable 0->1 using a registered copy; a rising edge seen in IDLE at cycle N SHALL give SETUP at N+1 with CS_n=0, busy=1, FLASH_data_out latched into the shift register, and MOSI=bit7.
REQ-016 SETUP SHALL last SCK_HALF cycles, then go to SCK_HI.
REQ-017 SCK_HI: SCK=1 for SCK_HALF cycles; on its last cycle, MISO SHALL be shifted into the receive register LSB.
REQ-018 SCK_LO: SCK=0 for SCK_HALF cycles; on entry, MOSI SHALL present the next bit; a 3-bit counter SHALL count bits.
REQ-019 After the 8th SCK_LO, the block SHALL load FLASH_data_in with the received byte, drop busy in the same cycle, and enter HOLD; busy time is SCK_HALF*17 cycles (34 at default).
REQ-020 HOLD: CS_n=0, SCK=0; a FLASH_continue_read pulse SHALL start a new exchange exactly as in REQ-015 (latch FLASH_data_out, enter SETUP next cycle, CS_n stays 0).
REQ-021 A FLASH_continue_read pulse arriving while busy SHALL be latched (one-deep pending flag) and served on entry to HOLD; further pulses during the same byte SHALL be discarded.
REQ-022 FLASH_enable=0 in HOLD SHALL give GAP next cycle: CS_n=1, busy=1 for CS_GAP cycles, then IDLE with busy=0.
REQ-023 FLASH_enable falling mid-byte SHALL NOT abort it; the byte completes, the pending flag is cleared, and HOLD is skipped in favour of GAP.
REQ-024 A FLASH_enable rising edge during GAP SHALL be held and acted on when IDLE is reached.
REQ-025 FLASH_continue_read in IDLE or GAP SHALL be ignored.
REQ-026 Simultaneous continue pulse and enable fall in HOLD: fall wins, go to GAP.

Reset
REQ-027 While reset=1 and asynchronously on its assertion: state=IDLE, CS_n=1, SCK=0, MOSI=0, busy=0, FLASH_data_in=0, pending=0, edge register=0.
REQ-028 Reset asserted mid-byte SHALL end the transaction immediately; after release, a new transaction requires a fresh FLASH_enable 0->1.

Verification
REQ-029 Enable 0->1, FLASH_data_out=0x9F, slave returns 0xA5 -> MOSI sends 10011111, FLASH_data_in=0xA5, busy high 34 cycles, CS_n stays low.
REQ-030 Open transaction, 3 continue pulses with 0x00, slave sends 0xEF,0x40,0x18 -> FLASH_data_in sequence matches, CS_n low throughout.
REQ-031 Continue pulse 10 cycles into a byte -> next byte starts on HOLD entry; a second pulse in the same byte is dropped (exactly one extra byte).
REQ-032 Enable falls at bit 3 -> byte completes, then CS_n high for 4 cycles; enable re-rises during gap -> SETUP starts after the gap.
REQ-033 Reset pulse at bit 5 -> CS_n=1, SCK=0, busy=0, FLASH_data_in=0 the same cycle; no SCK edges until the next enable rising edge.
REQ-034 SCK_HALF=1 -> SCK period 2 cycles, busy time 17 cycles, data correct.
